thread_scheduler: RTL and testbench
===================================

# thread_scheduler

Issue scheduler for the two hardware threads of the pipelined SIK stack processor. Holds each thread's program counter, stack pointer and halted flag. Each cycle it selects at most one thread to feed the shared fetch/decode/ALU path. Threads alternate round-robin; halted or stalled threads are skipped. The block also absorbs control-flow redirects, stack-pointer writebacks and `sys` halts from the back end, and raises the processor-wide `halt`.

## Interface
- `PC0_INIT`, 16'h0000, reset PC of thread 0
- `PC1_INIT`, 16'h0001, reset PC of thread 1
- `PC_STEP`, 16'd2, PC increment per issued instruction
- `SP_INIT`, 8'hFF, reset stack pointer of both threads

- `clk`  in  1  the single clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `stall_t0`, `stall_t1`  in  1 each  thread not ready this cycle, e.g. a pending load
- `redirect_valid`  in  1  jump/call/ret resolved this cycle
- `redirect_tid`  in  1  thread that owns the redirect
- `redirect_pc`  in  16  new PC for that thread
- `sp_wr`  in  1  stack-pointer writeback valid
- `sp_tid`  in  1  thread that owns the writeback
- `sp_new`  in  8  new stack pointer value
- `halt_req`  in  1  `sys` retired; halts a thread
- `halt_tid`  in  1  thread being halted
- `issue_valid`  out  1  an issue slot is valid this cycle
- `issue_tid`  out  1  thread owning the slot
- `issue_pc`  out  16  PC to fetch for the slot
- `issue_sp`  out  8  stack pointer for decode
- `halted_t0`, `halted_t1`  out  1 each  per-thread sticky halted flag
- `halt`  out  1  both threads halted

## Operation
- State: `pc[0:1]` (16b), `sp[0:1]` (8b), `halted[0:1]`, `last_tid` (1b).
- Eligibility: thread i is eligible when all of the following hold:
  - `!halted[i]` and `!stall_ti`;
  - not (`halt_req && halt_tid==i`);
  - not (`redirect_valid && redirect_tid==i`).
  - A redirected thread therefore loses exactly one slot, so no wrong-path instruction is issued.
- Selection:
  - Both threads eligible: pick `!last_tid`.
  - One thread eligible: pick it.
  - Neither eligible: no issue.
- On issue of thread s:
  - `issue_valid`<=1, `issue_tid`<=s, `issue_pc`<=`pc[s]`.
  - `issue_sp`<=(`sp_wr && sp_tid==s`) ? `sp_new` : `sp[s]`. The writeback is forwarded.
  - `pc[s]`<=`pc[s]+PC_STEP`, `last_tid`<=s.
- On no issue: `issue_valid`<=0. `issue_tid`, `issue_pc` and `issue_sp` hold their previous values, and `last_tid` is unchanged.
- Redirect: `pc[redirect_tid]`<=`redirect_pc`. It is ignored if that thread is already halted.
- SP writeback: `sp[sp_tid]`<=`sp_new`. It is ignored if that thread is already halted.
- Halt: `halted[halt_tid]`<=1. The flag is sticky until reset. Repeated halt requests have no further effect.
- Redirect and halt to the same thread in the same cycle: the halt wins and the PC is left unchanged.
- `halt`<=`halted[0] && halted[1]`, registered from the current flags.
- Arithmetic: PC addition is modulo 2^16 (16'hFFFE+2 = 16'h0000). SP is stored as given; the scheduler does no SP arithmetic.

## Timing
- Eligibility and selection are combinational from current state and inputs. All outputs are registered, so there is 1-cycle latency from input to output.
- Reset (async assert, any time, including mid-operation) forces:
  - `pc[0]`=`PC0_INIT`, `pc[1]`=`PC1_INIT`, `sp[*]`=`SP_INIT`;
  - `halted[*]`=0, `last_tid`=1, so thread 0 issues first;
  - `issue_valid`=0, `issue_tid`=0, `issue_pc`=0, `issue_sp`=`SP_INIT`;
  - `halted_t0`=`halted_t1`=0, `halt`=0.
- First issue occurs on the first rising edge after `reset` deasserts.
- `halted_tN` rises on the edge that samples `halt_req`. `halt` rises one edge after the second thread's halted flag is set.
- Steady state with no stalls: the slots alternate t0,t1,t0,t1, one per cycle.
- While one thread is halted, the other issues every cycle, subject to its stall input.

## Test plan
- Reset, no stalls, 6 cycles: slots read (t0,0000),(t1,0001),(t0,0002),(t1,0003),(t0,0004),(t1,0005), with `issue_sp`=FF on every slot.
- Hold `stall_t1`=1 for 3 cycles: thread 0 issues PCs 0000, 0002, 0004 back-to-back. On release, thread 1 issues next at PC 0001.
- `redirect_valid`=1, tid=0, pc=0040 in a cycle where thread 0 would issue:
  - that cycle issues thread 1;
  - the next thread-0 slot has `issue_pc`=0040, and the slot after it 0042.
- `halt_req` for t0, then 4 cycles later for t1:
  - `halted_t0` sets the next edge; thread 1 then issues every cycle;
  - after the t1 halt, `issue_valid` drops to 0, and `halt` is 1 two edges after the t1 request;
  - a subsequent redirect to either thread leaves `halt` and `issue_valid` unchanged.
- PC wrap plus forwarding:
  - redirect t1 to FFFE: issues FFFE, then 0000;
  - `sp_wr` tid=1, sp_new=0x10, in the same cycle as a t1 issue: `issue_sp`=10.
- Async reset asserted mid-cycle while both threads are active: all outputs return to their reset values immediately, without waiting for a clock edge, and issue restarts at (t0,`PC0_INIT`).

Source files
------------

// File: rtl/thread_scheduler_if.sv
// Bundles the back-end control and issue-slot signals of the two-thread scheduler.
// The master side is the pipeline/back end; the slave side is the scheduler.
interface thread_scheduler_if;
    logic        stall_t0;
    logic        stall_t1;
    logic        redirect_valid;
    logic        redirect_tid;
    logic [15:0] redirect_pc;
    logic        sp_wr;
    logic        sp_tid;
    logic [7:0]  sp_new;
    logic        halt_req;
    logic        halt_tid;
    logic        issue_valid;
    logic        issue_tid;
    logic [15:0] issue_pc;
    logic [7:0]  issue_sp;
    logic        halted_t0;
    logic        halted_t1;
    logic        halt;

    modport master (
        output stall_t0, stall_t1, redirect_valid, redirect_tid, redirect_pc,
               sp_wr, sp_tid, sp_new, halt_req, halt_tid,
        input  issue_valid, issue_tid, issue_pc, issue_sp,
               halted_t0, halted_t1, halt
    );

    modport slave (
        input  stall_t0, stall_t1, redirect_valid, redirect_tid, redirect_pc,
               sp_wr, sp_tid, sp_new, halt_req, halt_tid,
        output issue_valid, issue_tid, issue_pc, issue_sp,
               halted_t0, halted_t1, halt
    );
endinterface

// File: rtl/thread_scheduler.sv
// Round-robin issue scheduler for the two hardware threads of the SIK stack processor.
// Tracks per-thread PC, SP and halted flag; all outputs are registered.
module thread_scheduler #(
    parameter logic [15:0] PC0_INIT = 16'h0000,
    parameter logic [15:0] PC1_INIT = 16'h0001,
    parameter logic [15:0] PC_STEP  = 16'd2,
    parameter logic [7:0]  SP_INIT  = 8'hFF
) (
    input  logic                clk,
    input  logic                reset,
    thread_scheduler_if.slave   bus
);

    logic [1:0][15:0] pc_q, pc_d;
    logic [1:0][7:0]  sp_q, sp_d;
    logic [1:0]       halted_q, halted_d;
    logic             last_tid_q, last_tid_d;
    logic             issue_valid_q, issue_valid_d;
    logic             issue_tid_q, issue_tid_d;
    logic [15:0]      issue_pc_q, issue_pc_d;
    logic [7:0]       issue_sp_q, issue_sp_d;
    logic             halt_q, halt_d;

    logic [1:0] stall_vec;
    logic [1:0] eligible;
    logic       sel_tid;
    logic       redirect_blocked;

    assign stall_vec = {bus.stall_t1, bus.stall_t0};

    // A thread being redirected or halted this cycle sits out, so no wrong-path slot is issued.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_elig
            assign eligible[gi] = !halted_q[gi] && !stall_vec[gi]
                               && !(bus.halt_req && (bus.halt_tid == 1'(gi)))
                               && !(bus.redirect_valid && (bus.redirect_tid == 1'(gi)));
        end
    endgenerate

    always_comb begin
        pc_d          = pc_q;
        sp_d          = sp_q;
        halted_d      = halted_q;
        last_tid_d    = last_tid_q;
        issue_valid_d = 1'b0;
        issue_tid_d   = issue_tid_q;
        issue_pc_d    = issue_pc_q;
        issue_sp_d    = issue_sp_q;
        halt_d        = halted_q[0] && halted_q[1];

        sel_tid = (eligible[0] && eligible[1]) ? ~last_tid_q : eligible[1];

        if (eligible != 2'b00) begin
            issue_valid_d     = 1'b1;
            issue_tid_d       = sel_tid;
            issue_pc_d        = pc_q[sel_tid];
            issue_sp_d        = (bus.sp_wr && (bus.sp_tid == sel_tid)) ? bus.sp_new : sp_q[sel_tid];
            pc_d[sel_tid]     = pc_q[sel_tid] + PC_STEP;
            last_tid_d        = sel_tid;
        end

        // A redirected thread is never the issuing one, so the PC write cannot collide with the increment.
        redirect_blocked = halted_q[bus.redirect_tid]
                        || (bus.halt_req && (bus.halt_tid == bus.redirect_tid));
        if (bus.redirect_valid && !redirect_blocked) begin
            pc_d[bus.redirect_tid] = bus.redirect_pc;
        end

        if (bus.sp_wr && !halted_q[bus.sp_tid]) begin
            sp_d[bus.sp_tid] = bus.sp_new;
        end

        if (bus.halt_req) begin
            halted_d[bus.halt_tid] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= {PC1_INIT, PC0_INIT};
            sp_q          <= {SP_INIT, SP_INIT};
            halted_q      <= 2'b00;
            last_tid_q    <= 1'b1;
            issue_valid_q <= 1'b0;
            issue_tid_q   <= 1'b0;
            issue_pc_q    <= 16'h0000;
            issue_sp_q    <= SP_INIT;
            halt_q        <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            sp_q          <= sp_d;
            halted_q      <= halted_d;
            last_tid_q    <= last_tid_d;
            issue_valid_q <= issue_valid_d;
            issue_tid_q   <= issue_tid_d;
            issue_pc_q    <= issue_pc_d;
            issue_sp_q    <= issue_sp_d;
            halt_q        <= halt_d;
        end
    end

    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_tid   = issue_tid_q;
    assign bus.issue_pc    = issue_pc_q;
    assign bus.issue_sp    = issue_sp_q;
    assign bus.halted_t0   = halted_q[0];
    assign bus.halted_t1   = halted_q[1];
    assign bus.halt        = halt_q;

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed + randomized bench for thread_scheduler against a slot-level reference model.
module tb_thread_scheduler;

    logic clk = 1'b0;
    logic reset = 1'b1;
    thread_scheduler_if intf();

    thread_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state, advanced once per clock from the rules of operation.
    int       m_pc[2];
    bit [7:0] m_sp[2];
    bit       m_halted[2];
    int       m_last;
    bit       exp_valid;
    bit       exp_tid;
    bit [15:0] exp_pc;
    bit [7:0] exp_sp;
    bit       exp_halt;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".valid"},   32'(intf.issue_valid), 32'(exp_valid));
        chk({tag, ".tid"},     32'(intf.issue_tid),   32'(exp_tid));
        chk({tag, ".pc"},      32'(intf.issue_pc),    32'(exp_pc));
        chk({tag, ".sp"},      32'(intf.issue_sp),    32'(exp_sp));
        chk({tag, ".halted0"}, 32'(intf.halted_t0),   32'(m_halted[0]));
        chk({tag, ".halted1"}, 32'(intf.halted_t1),   32'(m_halted[1]));
        chk({tag, ".halt"},    32'(intf.halt),        32'(exp_halt));
    endtask

    task automatic model_reset();
        m_pc[0] = 0; m_pc[1] = 1;
        m_sp[0] = 8'hFF; m_sp[1] = 8'hFF;
        m_halted[0] = 0; m_halted[1] = 0;
        m_last = 1;
        exp_valid = 0; exp_tid = 0; exp_pc = 0; exp_sp = 8'hFF; exp_halt = 0;
    endtask

    task automatic model_step();
        bit e[2];
        bit st[2];
        int s;
        int rt, ht, wt;
        st[0] = intf.stall_t0; st[1] = intf.stall_t1;
        rt = int'(intf.redirect_tid); ht = int'(intf.halt_tid); wt = int'(intf.sp_tid);
        for (int i = 0; i < 2; i++)
            e[i] = !m_halted[i] && !st[i] && !(intf.halt_req && ht == i)
                   && !(intf.redirect_valid && rt == i);
        exp_halt = m_halted[0] && m_halted[1];
        if (e[0] || e[1]) begin
            if (e[0] && e[1]) s = 1 - m_last;
            else              s = e[0] ? 0 : 1;
            exp_valid = 1;
            exp_tid   = s[0];
            exp_pc    = m_pc[s][15:0];
            exp_sp    = (intf.sp_wr && wt == s) ? intf.sp_new : m_sp[s];
            m_pc[s]   = (m_pc[s] + 2) % 65536;
            m_last    = s;
        end else begin
            exp_valid = 0;
        end
        if (intf.redirect_valid && !m_halted[rt] && !(intf.halt_req && ht == rt))
            m_pc[rt] = int'(intf.redirect_pc);
        if (intf.sp_wr && !m_halted[wt]) m_sp[wt] = intf.sp_new;
        if (intf.halt_req) m_halted[ht] = 1;
    endtask

    task automatic clear_in();
        intf.stall_t0 = 0; intf.stall_t1 = 0;
        intf.redirect_valid = 0; intf.redirect_tid = 0; intf.redirect_pc = 0;
        intf.sp_wr = 0; intf.sp_tid = 0; intf.sp_new = 0;
        intf.halt_req = 0; intf.halt_tid = 0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick(string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        clear_in();
        model_reset();
        @(negedge clk);
        #1;
        check_all("reset_hold");
        @(negedge clk);
        reset = 1'b0;

        // Free-running alternation straight out of reset.
        for (int i = 0; i < 6; i++) begin
            tick("alt");
            chk("alt_tid_lit", 32'(intf.issue_tid), 32'(i % 2));
            chk("alt_pc_lit",  32'(intf.issue_pc),  32'(i));
            chk("alt_sp_lit",  32'(intf.issue_sp),  32'hFF);
        end

        // Thread 1 stalled: thread 0 runs back-to-back.
        intf.stall_t1 = 1;
        for (int i = 0; i < 3; i++) begin
            tick("stall1");
            chk("stall1_pc_lit", 32'(intf.issue_pc), 32'(6 + 2 * i));
        end
        intf.stall_t1 = 0;
        tick("release");
        chk("release_pc_lit", 32'(intf.issue_pc), 32'h0007);

        // Redirect thread 0 in its own slot.
        intf.redirect_valid = 1; intf.redirect_tid = 0; intf.redirect_pc = 16'h0040;
        tick("redir");
        chk("redir_tid_lit", 32'(intf.issue_tid), 32'd1);
        clear_in();
        tick("redir_a");
        chk("redir_pc40", 32'(intf.issue_pc), 32'h0040);
        tick("redir_b");
        tick("redir_c");
        chk("redir_pc42", 32'(intf.issue_pc), 32'h0042);

        // PC wrap on thread 1, then SP writeback forwarded into a t1 slot.
        intf.redirect_valid = 1; intf.redirect_tid = 1; intf.redirect_pc = 16'hFFFE;
        tick("wrap_redir");
        clear_in();
        intf.stall_t0 = 1;
        tick("wrap_a");
        chk("wrap_pc_fffe", 32'(intf.issue_pc), 32'hFFFE);
        intf.sp_wr = 1; intf.sp_tid = 1; intf.sp_new = 8'h10;
        tick("wrap_b");
        chk("wrap_pc_0000", 32'(intf.issue_pc), 32'h0000);
        chk("fwd_sp_10",    32'(intf.issue_sp), 32'h10);
        clear_in();
        tick("wrap_c");

        // Randomized traffic without halts.
        for (int i = 0; i < 200; i++) begin
            intf.stall_t0 = ($urandom_range(0, 3) == 0);
            intf.stall_t1 = ($urandom_range(0, 3) == 0);
            intf.redirect_valid = ($urandom_range(0, 7) == 0);
            intf.redirect_tid = 1'($urandom);
            intf.redirect_pc = 16'($urandom);
            intf.sp_wr = ($urandom_range(0, 3) == 0);
            intf.sp_tid = 1'($urandom);
            intf.sp_new = 8'($urandom);
            tick("rand");
        end
        clear_in();

        // Halt t0, then t1 four cycles later.
        intf.halt_req = 1; intf.halt_tid = 0;
        tick("halt0");
        chk("halt0_flag", 32'(intf.halted_t0), 32'd1);
        clear_in();
        for (int i = 0; i < 3; i++) begin
            tick("halt0_run");
            chk("halt0_run_tid", 32'(intf.issue_tid), 32'd1);
        end
        intf.halt_req = 1; intf.halt_tid = 1;
        tick("halt1");
        clear_in();
        tick("halt1_a");
        chk("halt_lit",  32'(intf.halt),        32'd1);
        chk("halt_idle", 32'(intf.issue_valid), 32'd0);
        intf.redirect_valid = 1; intf.redirect_tid = 0; intf.redirect_pc = 16'h1234;
        tick("halted_redir0");
        intf.redirect_tid = 1;
        tick("halted_redir1");
        clear_in();
        tick("halted_idle");

        // Asynchronous reset mid-cycle while both threads are active.
        do_reset();
        for (int i = 0; i < 5; i++) tick("pre_async");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b0;
        tick("post_async");
        chk("post_async_pc", 32'(intf.issue_pc), 32'h0000);

        // Randomized traffic including halts; reset whenever both threads stop.
        for (int i = 0; i < 400; i++) begin
            intf.stall_t0 = ($urandom_range(0, 3) == 0);
            intf.stall_t1 = ($urandom_range(0, 3) == 0);
            intf.redirect_valid = ($urandom_range(0, 5) == 0);
            intf.redirect_tid = 1'($urandom);
            intf.redirect_pc = 16'($urandom);
            intf.sp_wr = ($urandom_range(0, 2) == 0);
            intf.sp_tid = 1'($urandom);
            intf.sp_new = 8'($urandom);
            intf.halt_req = ($urandom_range(0, 19) == 0);
            intf.halt_tid = 1'($urandom);
            tick("rand_h");
            if (m_halted[0] && m_halted[1] && exp_halt) begin
                clear_in();
                do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
